// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_if
// Description : Instruction-memory read port plus the decode valid/ready
//               handshake driven by fetch_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 18
) ();

  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_instr;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;

  modport master (
    output mem_addr,
    input  mem_instr,
    output instr_out,
    output instr_pc,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  mem_addr,
    output mem_instr,
    input  instr_out,
    input  instr_pc,
    input  instr_valid,
    output instr_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Program counter and fetch controller for the instruction
//               memory; registers each word and offers it to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 18,
  parameter logic [2:0]  HALT_OP = 3'b111
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [ADDR_W-1:0]  end_addr,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  fetch_sequencer_if.master  bus,
  output logic               busy,
  output logic               done,
  output logic [15:0]        issued
);

  localparam logic [1:0] c_IDLE  = 2'b00;
  localparam logic [1:0] c_RUN   = 2'b01;
  localparam logic [1:0] c_DRAIN = 2'b10;
  localparam logic [1:0] c_DONE  = 2'b11;

  localparam logic [15:0]       c_ISSUED_MAX = 16'hFFFF;
  localparam logic [15:0]       c_ISSUED_INC = 16'h0001;
  localparam logic [ADDR_W-1:0] c_PC_INC     = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]         r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_end_q;
  logic [INSTR_W-1:0] r_instr_out;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic               r_instr_valid;
  logic [15:0]        r_issued;

  logic w_running;
  logic w_idle;
  logic w_load;
  logic w_handshake;
  logic w_flush;
  logic w_launch;
  logic w_stop;

  assign w_running   = (r_state == c_RUN) || (r_state == c_DRAIN);
  assign w_idle      = (r_state == c_IDLE) || (r_state == c_DONE);
  assign w_load      = !r_instr_valid || bus.instr_ready;
  assign w_handshake = r_instr_valid && bus.instr_ready;
  assign w_flush     = redirect && w_running;
  assign w_launch    = start && w_idle;
  // The word being loaded is the last of the run: HALT or the end address.
  assign w_stop      = (bus.mem_instr[2:0] == HALT_OP) || (r_pc == r_end_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_IDLE;
      r_pc          <= '0;
      r_end_q       <= '0;
      r_instr_out   <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else if (w_flush) begin
      r_instr_valid <= 1'b0;
      r_pc          <= redirect_addr;
      r_state       <= c_RUN;
    end else begin
      case (r_state)
        c_IDLE, c_DONE: begin
          if (start) begin
            r_pc          <= start_addr;
            r_end_q       <= end_addr;
            r_instr_valid <= 1'b0;
            r_state       <= c_RUN;
          end
        end
        c_RUN: begin
          if (w_load) begin
            r_instr_out   <= bus.mem_instr;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_pc          <= r_pc + c_PC_INC;
            if (w_stop) begin
              r_state <= c_DRAIN;
            end
          end
        end
        c_DRAIN: begin
          if (w_handshake) begin
            r_instr_valid <= 1'b0;
            r_state       <= c_DONE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Accepted-instruction counter; a flushed handshake is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued <= '0;
    end else if (w_launch) begin
      r_issued <= '0;
    end else if (w_handshake && !redirect && (r_issued != c_ISSUED_MAX)) begin
      r_issued <= r_issued + c_ISSUED_INC;
    end
  end

  assign bus.mem_addr    = r_pc;
  assign bus.instr_out   = r_instr_out;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_instr_valid;
  assign busy            = w_running;
  assign done            = (r_state == c_DONE);
  assign issued          = r_issued;

endmodule
`default_nettype wire
